// File: rtl/load_store_unit.sv
// RV32I load/store unit: accepts one core request at a time, checks legality and
// alignment, drives a 1-cycle-latency synchronous SRAM, and returns aligned/extended load data.
module load_store_unit #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [WORD_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [WORD_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic                  mem_we,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  input  logic [WORD_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t state_q, state_d;

  logic                  we_q;
  logic [2:0]            funct3_q;
  logic [1:0]            lane_q;
  logic                  accept;
  logic                  req_bad;
  logic [WORD_WIDTH-1:0] store_data;
  logic [WORD_WIDTH-1:0] load_data;
  logic [WORD_WIDTH-1:0] shifted;
  logic [7:0]            byte_v;
  logic [15:0]           half_v;
  logic                  unused_addr_bits;

  // Address bits above the SRAM window are ignored, so addresses wrap.
  assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH+2];

  assign accept = req_valid && (state_q == IDLE);

  always_comb begin
    req_bad = 1'b0;
    case (req_funct3)
      3'b000:  req_bad = 1'b0;
      3'b001:  req_bad = req_addr[0];
      3'b010:  req_bad = |req_addr[1:0];
      3'b100:  req_bad = req_we;
      3'b101:  req_bad = req_we | req_addr[0];
      default: req_bad = 1'b1;
    endcase
  end

  always_comb begin
    store_data = req_wdata;
    case (req_funct3[1:0])
      2'b00:   store_data = {4{req_wdata[7:0]}};
      2'b01:   store_data = {2{req_wdata[15:0]}};
      default: store_data = req_wdata;
    endcase
  end

  always_comb begin
    shifted   = mem_rdata >> {lane_q, 3'b000};
    byte_v    = shifted[7:0];
    half_v    = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_data = mem_rdata;
    case (funct3_q)
      3'b000:  load_data = {{24{byte_v[7]}}, byte_v};
      3'b001:  load_data = {{16{half_v[15]}}, half_v};
      3'b100:  load_data = {24'h0, byte_v};
      3'b101:  load_data = {16'h0, half_v};
      default: load_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      funct3_q  <= '0;
      lane_q    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q     <= req_we;
        funct3_q <= req_funct3;
        lane_q   <= req_addr[1:0];
        if (req_bad) begin
          rsp_err   <= 1'b1;
          rsp_rdata <= '0;
        end else begin
          mem_addr <= req_addr[ADDR_WIDTH+1:2];
          if (req_we) mem_wdata <= store_data;
        end
      end
      // Response registers change only on entry to RESP, so they hold in between.
      if (state_q == ACCESS && we_q) begin
        rsp_err   <= 1'b0;
        rsp_rdata <= '0;
      end
      if (state_q == WAIT) begin
        rsp_err   <= 1'b0;
        rsp_rdata <= load_data;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = req_bad ? RESP : ACCESS;
      end
      ACCESS: begin
        mem_we = we_q;
        if (we_q) begin
          case (funct3_q[1:0])
            2'b00:   mem_be = 4'b0001 << lane_q;
            2'b01:   mem_be = lane_q[1] ? 4'b1100 : 4'b0011;
            default: mem_be = 4'b1111;
          endcase
        end else begin
          mem_be = 4'b1111;
        end
        state_d = we_q ? RESP : WAIT;
      end
      WAIT: state_d = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: SRAM model plus a byte-addressed reference model.
module tb_load_store_unit;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [2:0]    req_funct3 = 3'b000;
  logic [31:0]   req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_be;
  logic          mem_we;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = '0;

  int total = 0;
  int bad = 0;

  logic [31:0] sram [0:(1<<AW)-1];
  logic [7:0]  ref_mem [0:(1<<(AW+2))-1];

  load_store_unit #(.ADDR_WIDTH(AW), .WORD_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++)
        if (mem_be[i]) sram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
    end
    mem_rdata <= sram[mem_addr];
  end

  task automatic ref_model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, output logic e_err, output logic [31:0] e_rd,
                           output logic [3:0] e_be, output logic [31:0] e_wd,
                           output logic [AW-1:0] e_ma, output int e_lat);
    int unsigned size, lane, base;
    logic sgn, legal;
    longint val;
    size = 1; sgn = 1'b0; legal = 1'b1;
    case (f3)
      3'd0: begin size = 1; sgn = 1'b1; end
      3'd1: begin size = 2; sgn = 1'b1; end
      3'd2: size = 4;
      3'd4: begin size = 1; legal = !we; end
      3'd5: begin size = 2; legal = !we; end
      default: legal = 1'b0;
    endcase
    lane  = addr % 4;
    base  = (addr % (1 << (AW + 2))) - lane;
    e_ma  = AW'((addr / 4) % (1 << AW));
    e_err = !legal || (addr % size != 0);
    e_rd  = '0; e_be = 4'hF; e_wd = '0;
    if (e_err) e_lat = 1;
    else if (we) begin
      e_lat = 2;
      e_be  = 4'(((1 << size) - 1) << lane);
      for (int i = 0; i < 4; i++) e_wd[8*i +: 8] = wd[8*(i % size) +: 8];
      for (int i = 0; i < int'(size); i++) ref_mem[base + lane + i] = wd[8*i +: 8];
    end else begin
      e_lat = 3;
      val = 0;
      for (int i = 0; i < int'(size); i++) val = val + (longint'(ref_mem[base + lane + i]) << (8*i));
      if (sgn && val >= (longint'(1) << (8*size - 1))) val = val - (longint'(1) << (8*size));
      e_rd = val[31:0];
    end
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] got);
    logic e_err; logic [31:0] e_rd, e_wd; logic [3:0] e_be; logic [AW-1:0] e_ma; int e_lat;
    int g, lat, nwe, nbe;
    logic [3:0] c_be; logic [AW-1:0] c_ma; logic [31:0] c_wd;
    ref_model(we, f3, addr, wd, e_err, e_rd, e_be, e_wd, e_ma, e_lat);
    g = 0;
    while (!req_ready && g < 20) begin @(negedge clk); g++; end
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL ready_wait: req_ready=%b want 1", req_ready); end
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    lat = 0; nwe = 0; nbe = 0; c_be = '0; c_ma = '0; c_wd = '0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (mem_be != 4'b0) begin nbe++; c_be = mem_be; c_ma = mem_addr; c_wd = mem_wdata; end
      if (mem_we) nwe++;
      if (rsp_valid) begin lat = k; break; end
    end
    total++;
    if (lat != e_lat) begin bad++; $display("FAIL latency we=%b f3=%0d addr=%h: got %0d want %0d", we, f3, addr, lat, e_lat); end
    total++;
    if (rsp_err !== e_err) begin bad++; $display("FAIL rsp_err addr=%h f3=%0d: got %b want %b", addr, f3, rsp_err, e_err); end
    total++;
    if (rsp_rdata !== e_rd) begin bad++; $display("FAIL rsp_rdata we=%b f3=%0d addr=%h: got %h want %h", we, f3, addr, rsp_rdata, e_rd); end
    total++;
    if (nwe != ((!e_err && we) ? 1 : 0)) begin bad++; $display("FAIL write_count addr=%h: got %0d want %0d", addr, nwe, (!e_err && we) ? 1 : 0); end
    total++;
    if (nbe != (e_err ? 0 : 1)) begin bad++; $display("FAIL be_cycles addr=%h: got %0d want %0d", addr, nbe, e_err ? 0 : 1); end
    if (!e_err) begin
      total++;
      if (c_be !== e_be) begin bad++; $display("FAIL mem_be f3=%0d addr=%h: got %b want %b", f3, addr, c_be, e_be); end
      total++;
      if (c_ma !== e_ma) begin bad++; $display("FAIL mem_addr addr=%h: got %h want %h", addr, c_ma, e_ma); end
      if (we) begin
        total++;
        if (c_wd !== e_wd) begin bad++; $display("FAIL mem_wdata f3=%0d: got %h want %h", f3, c_wd, e_wd); end
      end
    end
    got = rsp_rdata;
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL after_resp: rsp_valid=%b req_ready=%b want 0/1", rsp_valid, req_ready);
    end
    total++;
    if (rsp_rdata !== e_rd || rsp_err !== e_err) begin
      bad++; $display("FAIL hold: rdata=%h err=%b want %h/%b", rsp_rdata, rsp_err, e_rd, e_err);
    end
  endtask

  task automatic test_reset;
    req_valid = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({req_ready, rsp_valid, rsp_err, mem_we, mem_be} !== 8'b1000_0000 ||
        rsp_rdata !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
      bad++;
      $display("FAIL reset_state: ready=%b rv=%b err=%b we=%b be=%b rd=%h ma=%h wd=%h want 1 0 0 0 0000 0 0 0",
               req_ready, rsp_valid, rsp_err, mem_we, mem_be, rsp_rdata, mem_addr, mem_wdata);
    end
    req_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed;
    logic [31:0] got;
    do_req(1'b1, 3'd2, 32'h0000_0008, 32'hDEADBEEF, got);
    do_req(1'b1, 3'd0, 32'h0000_0005, 32'h0000_00A5, got);
    do_req(1'b0, 3'd0, 32'h0000_0005, 32'h0, got);
    total++;
    if (got !== 32'hFFFF_FFA5) begin bad++; $display("FAIL lb_a5: got %h want ffffffa5", got); end
    do_req(1'b0, 3'd4, 32'h0000_0005, 32'h0, got);
    total++;
    if (got !== 32'h0000_00A5) begin bad++; $display("FAIL lbu_a5: got %h want 000000a5", got); end
    do_req(1'b1, 3'd2, 32'h0000_0000, 32'h8001_1234, got);
    do_req(1'b0, 3'd1, 32'h0000_0002, 32'h0, got);
    total++;
    if (got !== 32'hFFFF_8001) begin bad++; $display("FAIL lh_8001: got %h want ffff8001", got); end
    do_req(1'b0, 3'd5, 32'h0000_0000, 32'h0, got);
    total++;
    if (got !== 32'h0000_1234) begin bad++; $display("FAIL lhu_1234: got %h want 00001234", got); end
  endtask

  task automatic test_errors;
    logic [31:0] got;
    do_req(1'b0, 3'd2, 32'h0000_0002, 32'h0, got);
    do_req(1'b1, 3'd1, 32'h0000_0001, 32'h1234_5678, got);
    do_req(1'b0, 3'd3, 32'h0000_0010, 32'h0, got);
    do_req(1'b1, 3'd4, 32'h0000_0010, 32'h0, got);
    do_req(1'b0, 3'd5, 32'h0000_0003, 32'h0, got);
    do_req(1'b1, 3'd2, 32'h0000_0011, 32'h0, got);
  endtask

  task automatic test_back_to_back;
    logic e_err; logic [31:0] e_rd, e_wd; logic [3:0] e_be; logic [AW-1:0] e_ma; int e_lat;
    logic [31:0] got;
    bit r_exp [1:5] = '{0, 0, 1, 0, 0};
    bit w_exp [1:5] = '{1, 0, 0, 1, 0};
    bit v_exp [1:5] = '{0, 1, 0, 0, 1};
    ref_model(1'b1, 3'd2, 32'h0000_0040, 32'h1111_2222, e_err, e_rd, e_be, e_wd, e_ma, e_lat);
    ref_model(1'b1, 3'd2, 32'h0000_0044, 32'h3333_4444, e_err, e_rd, e_be, e_wd, e_ma, e_lat);
    req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h40; req_wdata = 32'h1111_2222; req_valid = 1'b1;
    @(posedge clk); #1 req_addr = 32'h44; req_wdata = 32'h3333_4444;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      total++;
      if (req_ready !== r_exp[n] || mem_we !== w_exp[n] || rsp_valid !== v_exp[n]) begin
        bad++;
        $display("FAIL b2b_cycle%0d: ready/we/rv=%b%b%b want %b%b%b", n, req_ready, mem_we, rsp_valid,
                 r_exp[n], w_exp[n], v_exp[n]);
      end
      if (n == 4) begin
        total++;
        if (mem_wdata !== 32'h3333_4444 || mem_addr !== AW'(17)) begin
          bad++; $display("FAIL b2b_second: wdata=%h addr=%h want 33334444/011", mem_wdata, mem_addr);
        end
      end
      if (n == 3) begin @(posedge clk); #1 req_valid = 1'b0; end
    end
    @(negedge clk);
    do_req(1'b0, 3'd2, 32'h0000_0040, 32'h0, got);
    do_req(1'b0, 3'd2, 32'h0000_0044, 32'h0, got);
  endtask

  task automatic test_reset_mid;
    logic [31:0] got;
    req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h80; req_wdata = 32'hCAFE_F00D; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    total++;
    if (mem_we !== 1'b1) begin bad++; $display("FAIL mid_access_we: got %b want 1", mem_we); end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (mem_we !== 1'b0 || mem_be !== 4'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL mid_abort: we=%b be=%b rv=%b ready=%b want 0 0000 0 1", mem_we, mem_be, rsp_valid, req_ready);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
        bad++; $display("FAIL mid_hold: rv=%b ma=%h wd=%h want 0 0 0", rsp_valid, mem_addr, mem_wdata);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    do_req(1'b0, 3'd2, 32'h0000_0080, 32'h0, got);
    do_req(1'b1, 3'd1, 32'h0000_0082, 32'h0000_BEEF, got);
    do_req(1'b0, 3'd2, 32'h0000_0080, 32'h0, got);
  endtask

  task automatic test_random;
    logic [31:0] got, r, a;
    logic w;
    logic [2:0] f;
    for (int n = 0; n < 120; n++) begin
      r = $urandom;
      a = (r & 32'hFFFF_C000) | 32'($urandom_range(0, 47));
      w = ($urandom_range(0, 2) == 0);
      f = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2));
      if (!w && $urandom_range(0, 2) == 0) f = 3'd4 | 3'($urandom_range(0, 1));
      do_req(w, f, a, $urandom, got);
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) sram[i] = '0;
    for (int i = 0; i < (1 << (AW + 2)); i++) ref_mem[i] = '0;
    fork
      begin
        test_reset;
        test_directed;
        test_errors;
        test_back_to_back;
        test_reset_mid;
        test_random;
      end
      begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
      end
    join_any
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 12, the memory word-address width.
REQ-002 The block SHALL have parameter WORD_WIDTH, default 32, the data width; only 32 is supported.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 The block SHALL have port req_valid, input, 1, core request valid.
REQ-006 The block SHALL have port req_ready, output, 1, the block can accept a request.
REQ-007 The block SHALL have port req_we, input, 1, with 1 = store and 0 = load.
REQ-008 The block SHALL have port req_funct3, input, 3, RV32I width/sign code.
REQ-009 The block SHALL have port req_addr, input, 32, byte address.
REQ-010 The block SHALL have port req_wdata, input, 32, store data, right-aligned.
REQ-011 The block SHALL have port rsp_valid, output, 1, a one-cycle completion pulse.
REQ-012 The block SHALL have port rsp_rdata, output, 32, aligned and extended load data.
REQ-013 The block SHALL have port rsp_err, output, 1, misaligned or illegal request; qualified by rsp_valid.
REQ-014 The block SHALL have the following ports to the synchronous SRAM with 1-cycle registered read: mem_addr output ADDR_WIDTH, mem_be output 4, mem_we output 1, mem_wdata output 32, mem_rdata input 32.

Function
REQ-015 The FSM SHALL have the states IDLE, ACCESS, WAIT and RESP.
REQ-016 req_ready SHALL be 1 only in IDLE.
REQ-017 A request SHALL be accepted on a rising edge where req_valid and req_ready are both 1; all request fields are captured at that edge.
REQ-018 On acceptance, the FSM SHALL go to RESP with the error flag set, and no memory access, if the request is illegal or misaligned; otherwise it SHALL go to ACCESS.
REQ-019 Legal funct3 codes SHALL be:
- loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU;
- stores: 000 SB, 001 SH, 010 SW;
- all others are illegal.
REQ-020 Alignment SHALL be misaligned for halfword when addr[0]=1, and for word when addr[1:0]!=0; byte accesses are never misaligned.
REQ-021 In ACCESS, mem_addr SHALL be req_addr[ADDR_WIDTH+1:2]; higher address bits are ignored, so addresses wrap modulo 2^(ADDR_WIDTH+2).
REQ-022 In ACCESS, mem_be SHALL be:
- SB: 1<<addr[1:0];
- SH: 0011 (addr[1]=0) or 1100 (addr[1]=1);
- SW and all loads: 1111.
REQ-023 In ACCESS, mem_wdata SHALL be {4{wdata[7:0]}} for SB, {2{wdata[15:0]}} for SH, and wdata for SW.
REQ-024 mem_we SHALL be 1 only during the ACCESS cycle of a store, so exactly one write per store.
REQ-025 Outside ACCESS, mem_we and mem_be SHALL be 0; mem_addr and mem_wdata hold their last value.
REQ-026 From ACCESS, a store SHALL go to RESP and a load SHALL go to WAIT.
REQ-027 In WAIT, the block SHALL sample mem_rdata, extract the lane selected by addr[1:0], sign-extend (LB, LH) or zero-extend (LBU, LHU), and register the result into rsp_rdata; the FSM then goes to RESP.
REQ-028 In RESP, rsp_valid SHALL be 1 for exactly one cycle, then the FSM returns to IDLE.
REQ-029 rsp_rdata SHALL be 0 for stores and for error responses; rsp_err SHALL be 1 only for error responses.
REQ-030 Latency from the acceptance edge SHALL be: load rsp_valid 3 cycles later, store 2 cycles later, error 1 cycle later.
REQ-031 Back-to-back requests SHALL be possible: a request held on req_valid is accepted in the IDLE cycle after RESP.
REQ-032 There SHALL be no response back-pressure; the core must consume the rsp_valid pulse.
REQ-033 rsp_rdata and rsp_err SHALL hold their values until the next response.

Reset
REQ-034 While rst_n=0, the block SHALL be in IDLE with req_ready=1 and rsp_valid, rsp_err, rsp_rdata, mem_we, mem_be, mem_addr and mem_wdata all 0.
REQ-035 Reset asserted mid-operation SHALL abort the transaction immediately (mem_we drops asynchronously) with no rsp_valid issued; operation resumes in IDLE on the first edge after rst_n=1.

Verification
REQ-036 SW addr=0x0000_0008, wdata=0xDEADBEEF -> one ACCESS cycle with mem_addr=2, mem_be=1111, mem_we=1, mem_wdata=0xDEADBEEF; rsp_valid 2 cycles after acceptance, rsp_err=0.
REQ-037 SB addr=0x0000_0005, wdata=0x0000_00A5 -> mem_addr=1, mem_be=0010, mem_wdata=0xA5A5A5A5; a following LB at 0x5 returns 0xFFFF_FFA5 and LBU returns 0x0000_00A5, each 3 cycles after acceptance.
REQ-038 LH addr=0x2 with word 0x8001_1234 -> rsp_rdata=0xFFFF_8001; LHU addr=0x0 -> 0x0000_1234.
REQ-039 LW addr=0x2, SH addr=0x1, and funct3=011 -> rsp_valid 1 cycle after acceptance with rsp_err=1, rsp_rdata=0, and mem_we never 1.
REQ-040 req_valid held high for two SW requests -> exactly two mem_we pulses, req_ready low during ACCESS and RESP, second acceptance in the cycle after the first rsp_valid.
REQ-041 rst_n pulled low during the ACCESS cycle of a store -> mem_we=0 immediately, no rsp_valid; the next request after release completes normally.
